// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: control-field codes, FSM states,
// ALU control values and the ALU control decoder.
package ex_pkg;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
   localparam logic [1:0] ALUOP_LUI    = 2'b11;

   localparam logic [1:0] JT_BTYPE = 2'b00;
   localparam logic [1:0] JT_JALR  = 2'b01;
   localparam logic [1:0] JT_JAL   = 2'b10;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_DIV_BUSY = 1'b1
   } ex_state_e;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_SRA  = 4'b1001,
      ALU_LUI  = 4'b1010
   } alu_ctrl_e;

   // SUB only for R-type (addi never subtracts); SRA/SRL selected by bit 30 in both forms.
   function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op, input logic [2:0] f3,
                                            input logic i30, input logic alu_src);
      alu_ctrl_e c;
      c = ALU_ADD;
      case (alu_op)
         ALUOP_ADD:    c = ALU_ADD;
         ALUOP_BRANCH: c = ALU_SUB;
         ALUOP_LUI:    c = ALU_LUI;
         default: begin
            case (f3)
               F3_ADD:  c = (i30 && !alu_src) ? ALU_SUB : ALU_ADD;
               F3_SLL:  c = ALU_SLL;
               F3_SLT:  c = ALU_SLT;
               F3_SLTU: c = ALU_SLTU;
               F3_XOR:  c = ALU_XOR;
               F3_SRL:  c = i30 ? ALU_SRA : ALU_SRL;
               F3_OR:   c = ALU_OR;
               default: c = ALU_AND;
            endcase
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative restoring divider, one quotient bit per cycle; operands are made
// positive on start and the signs are restored on the combinational outputs.
module ex_divider
   import ex_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic            is_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done_c,
   output logic [XLEN-1:0] quotient_c,
   output logic [XLEN-1:0] remainder_c
);

   localparam int unsigned CW = $clog2(XLEN + 1);

   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic [XLEN:0]   trial;

   always_comb begin
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
      if (abort) begin
         busy_d = 1'b0;
      end else if (start) begin
         busy_d    = 1'b1;
         cnt_d     = CW'(XLEN);
         rem_d     = '0;
         quo_d     = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
         dvs_d     = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
         neg_quo_d = is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
         neg_rem_d = is_signed && dividend[XLEN-1];
      end else if (busy_q) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            // quo_q doubles as the dividend shift register feeding the remainder
            if (!trial[XLEN]) begin
               rem_d = trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign busy        = busy_q;
   assign done_c      = busy_q && (cnt_q == '0);
   assign quotient_c  = neg_quo_q ? -quo_q : quo_q;
   assign remainder_c = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage_pipelined.sv
// Execute stage: ALU, branch resolve, link/target generation, optional M ops,
// registered EX/MEM slot with valid/ready and a one-cycle redirect pulse.
module ex_stage_pipelined
   import ex_pkg::*;
#(
   parameter int unsigned XLEN          = 32,
   parameter bit          ENABLE_MULDIV = 1'b1,
   parameter int unsigned BR_IMM_SHL    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] readData1,
   input  logic [XLEN-1:0] readData2,
   input  logic [XLEN-1:0] immGenOut,
   input  logic [2:0]      funct3,
   input  logic            i30,
   input  logic            i25,
   input  logic [1:0]      ALUOp,
   input  logic            ALUSrc,
   input  logic            branch,
   input  logic [1:0]      jumpType,
   input  logic [4:0]      in_rd,
   input  logic            in_regWrite,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUResult,
   output logic [4:0]      out_rd,
   output logic            out_regWrite,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   localparam int unsigned SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [XLEN-1:0]   op_b, alu_res, mul_res, div_spec_res, exec_res, br_tgt, jalr_sum, target;
   logic [SHW-1:0]    shamt;
   alu_ctrl_e         alu_ctrl;
   logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
   logic              is_m, is_div, div_zero, div_ovf, div_start, accept;
   logic              is_jump, br_cond, taken, div_busy, div_done_c;
   logic [XLEN-1:0]   div_quo_c, div_rem_c;

   ex_state_e         state_q, state_d;
   logic              out_valid_q, out_valid_d, redirect_valid_q, redirect_valid_d;
   logic              out_regwrite_q, out_regwrite_d, pend_rw_q, pend_rw_d, pend_rem_q, pend_rem_d;
   logic [XLEN-1:0]   alu_result_q, alu_result_d, redirect_pc_q, redirect_pc_d;
   logic [4:0]        out_rd_q, out_rd_d, pend_rd_q, pend_rd_d;

   assign op_b     = ALUSrc ? immGenOut : readData2;
   assign shamt    = op_b[SHW-1:0];
   assign alu_ctrl = alu_decode(ALUOp, funct3, i30, ALUSrc);

   always_comb begin
      case (alu_ctrl)
         ALU_AND:  alu_res = readData1 & op_b;
         ALU_OR:   alu_res = readData1 | op_b;
         ALU_ADD:  alu_res = readData1 + op_b;
         ALU_XOR:  alu_res = readData1 ^ op_b;
         ALU_SLL:  alu_res = readData1 << shamt;
         ALU_SRL:  alu_res = readData1 >> shamt;
         ALU_SUB:  alu_res = readData1 - op_b;
         ALU_SLT:  alu_res = XLEN'($signed(readData1) < $signed(op_b));
         ALU_SLTU: alu_res = XLEN'(readData1 < op_b);
         ALU_SRA:  alu_res = XLEN'($signed(readData1) >>> shamt);
         ALU_LUI:  alu_res = immGenOut;
         default:  alu_res = '0;
      endcase
   end

   // Sign/zero-extend to 2*XLEN so one unsigned multiply serves all four variants.
   assign is_m    = ENABLE_MULDIV && (ALUOp == ALUOP_FUNCT) && i25 && !ALUSrc;
   assign mul_a   = {{XLEN{((funct3 == F3_MULH) || (funct3 == F3_MULHSU)) & readData1[XLEN-1]}}, readData1};
   assign mul_b   = {{XLEN{(funct3 == F3_MULH) & op_b[XLEN-1]}}, op_b};
   assign mul_p   = mul_a * mul_b;
   assign mul_res = (funct3 == F3_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

   assign is_div    = is_m && funct3[2];
   assign div_zero  = (op_b == '0);
   assign div_ovf   = !funct3[0] && (readData1 == INT_MIN) && (&op_b);
   assign div_spec_res = div_zero ? (funct3[1] ? readData1 : '1)
                                  : (funct3[1] ? '0 : readData1);

   always_comb begin
      case (funct3)
         F3_BEQ:  br_cond = (readData1 == readData2);
         F3_BNE:  br_cond = (readData1 != readData2);
         F3_BLT:  br_cond = ($signed(readData1) < $signed(readData2));
         F3_BGE:  br_cond = ($signed(readData1) >= $signed(readData2));
         F3_BLTU: br_cond = (readData1 < readData2);
         F3_BGEU: br_cond = (readData1 >= readData2);
         default: br_cond = 1'b0;
      endcase
   end

   assign is_jump  = branch && ((jumpType == JT_JAL) || (jumpType == JT_JALR));
   assign taken    = is_jump || (branch && (jumpType == JT_BTYPE) && br_cond);
   assign br_tgt   = ex_pc + (immGenOut << BR_IMM_SHL);
   assign jalr_sum = readData1 + immGenOut;
   assign target   = (jumpType == JT_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : br_tgt;

   assign exec_res = is_jump ? (ex_pc + XLEN'(4))
                   : is_m    ? (funct3[2] ? div_spec_res : mul_res)
                   : alu_res;

   assign in_ready  = !flush && (state_q == ST_IDLE) && !div_busy && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign div_start = accept && is_div && !div_zero && !div_ovf;

   ex_divider #(.XLEN(XLEN)) u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (div_start),
      .abort       (flush),
      .is_signed   (!funct3[0]),
      .dividend    (readData1),
      .divisor     (op_b),
      .busy        (div_busy),
      .done_c      (div_done_c),
      .quotient_c  (div_quo_c),
      .remainder_c (div_rem_c)
   );

   // Slot/FSM next state; flush overrides everything, redirect defaults low for a single pulse.
   always_comb begin
      state_d          = state_q;
      out_valid_d      = out_valid_q;
      alu_result_d     = alu_result_q;
      out_rd_d         = out_rd_q;
      out_regwrite_d   = out_regwrite_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      pend_rd_d        = pend_rd_q;
      pend_rw_d        = pend_rw_q;
      pend_rem_d       = pend_rem_q;
      if (out_ready) out_valid_d = 1'b0;
      if (flush) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
      end else if (state_q == ST_DIV_BUSY) begin
         if (div_done_c) begin
            state_d        = ST_IDLE;
            out_valid_d    = 1'b1;
            alu_result_d   = pend_rem_q ? div_rem_c : div_quo_c;
            out_rd_d       = pend_rd_q;
            out_regwrite_d = pend_rw_q;
         end
      end else if (accept) begin
         if (div_start) begin
            state_d    = ST_DIV_BUSY;
            pend_rd_d  = in_rd;
            pend_rw_d  = in_regWrite;
            pend_rem_d = funct3[1];
         end else begin
            out_valid_d      = 1'b1;
            alu_result_d     = exec_res;
            out_rd_d         = in_rd;
            out_regwrite_d   = in_regWrite;
            redirect_valid_d = taken;
            if (taken) redirect_pc_d = target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         out_valid_q      <= 1'b0;
         alu_result_q     <= '0;
         out_rd_q         <= '0;
         out_regwrite_q   <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         pend_rd_q        <= '0;
         pend_rw_q        <= 1'b0;
         pend_rem_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         out_valid_q      <= out_valid_d;
         alu_result_q     <= alu_result_d;
         out_rd_q         <= out_rd_d;
         out_regwrite_q   <= out_regwrite_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         pend_rd_q        <= pend_rd_d;
         pend_rw_q        <= pend_rw_d;
         pend_rem_q       <= pend_rem_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign ALUResult      = alu_result_q;
   assign out_rd         = out_rd_q;
   assign out_regWrite   = out_regwrite_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule
